// File: rtl/regfile_write_arbiter.sv
// Shared write port for the register file, with a busy scoreboard.
// Define RF_WR_ARB_RR_EN for round-robin arbitration; fixed A-first otherwise.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  localparam int NREG = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              chk_en,
  input  logic [ADDR_W-1:0] chk_rs1,
  input  logic [ADDR_W-1:0] chk_rs2,
  input  logic [ADDR_W-1:0] chk_rd,
  output logic              hazard,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [NREG-1:0]   busy
);

  logic              grant_a;
  logic              grant_b;
  logic              xfer;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   busy_d;

`ifdef RF_WR_ARB_RR_EN
  logic last_b;

  // Grant goes to whichever side did not win last when both ask.
  always_comb begin
    grant_a = a_valid & (~b_valid | last_b);
    grant_b = b_valid & ~grant_a;
  end

  // Remember the last winner; reset as if B won so A goes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b <= 1'b1;
    end else if (xfer) begin
      last_b <= grant_b;
    end
  end
`else
  // A always wins; B only gets the port when A is idle.
  always_comb begin
    grant_a = a_valid;
    grant_b = b_valid & ~a_valid;
  end
`endif

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign xfer    = grant_a | grant_b;

  // Select the winning requester's address and data.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    unique case (1'b1)
      grant_a: begin
        wr_addr = a_addr;
        wr_data = a_data;
      end
      grant_b: begin
        wr_addr = b_addr;
        wr_data = b_data;
      end
      default: ;
    endcase
  end

  // Clear on write, then set on issue so a same-edge issue keeps it busy.
  always_comb begin
    busy_d = busy;
    if (xfer) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // Register the write port; address and data hold while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_we <= xfer;
      if (xfer) begin
        rf_wr_addr <= wr_addr;
        rf_wr_data <= wr_data;
      end
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_d;
    end
  end

  assign hazard = chk_en &
                  (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed cases plus random traffic
// checked every cycle against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rd = '0;
  logic          chk_en = 1'b0;
  logic [AW-1:0] chk_rs1 = '0, chk_rs2 = '0, chk_rd = '0;
  logic          hazard;
  logic          rf_we;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [NR-1:0] busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_addr(b_addr), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_en(chk_en), .chk_rs1(chk_rs1),
    .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .rf_we(rf_we),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_pend [NR];
  bit          m_we;
  int          m_addr;
  int          m_data;
  int          m_last;

  // 0 = nobody, 1 = A, 2 = B
  function automatic int winner();
    if (a_valid && b_valid) begin
`ifdef RF_WR_ARB_RR_EN
      return (m_last == 2) ? 1 : 2;
`else
      return 1;
`endif
    end
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      m_we = 1'b0;
      m_addr = 0;
      m_data = 0;
      m_last = 2;
    end else begin
      int w;
      w = winner();
      m_we = (w != 0);
      if (w == 1) begin
        m_addr = int'(a_addr);
        m_data = int'(a_data);
      end else if (w == 2) begin
        m_addr = int'(b_addr);
        m_data = int'(b_data);
      end
      if (w != 0) begin
        m_pend[m_addr] = 1'b0;
        m_last = w;
      end
      if (iss_valid) m_pend[iss_rd] = 1'b1;
    end
  end

  // Mid-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      int w;
      bit hz;
      w = winner();
      hz = chk_en && (m_pend[chk_rs1] || m_pend[chk_rs2]
                      || m_pend[chk_rd]);
      check("m_we", int'(rf_we), int'(m_we));
      check("m_addr", int'(rf_wr_addr), m_addr);
      check("m_data", int'(rf_wr_data), m_data);
      check("m_busy", int'(busy), int'(m_busy()));
      check("m_a_ready", int'(a_ready), int'(w == 1));
      check("m_b_ready", int'(b_ready), int'(w == 2));
      check("m_hazard", int'(hazard), int'(hz));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    a_valid = 1'b0;
    b_valid = 1'b0;
    iss_valid = 1'b0;
    chk_en = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    run_cmp = 1'b1;
    #1;
    check("rst_we", int'(rf_we), 0);
    check("rst_busy", int'(busy), 0);

    // Single write to r2 after issue
    iss_valid = 1'b1;
    iss_rd = 2'd2;
    step();
    iss_valid = 1'b0;
    #1;
    check("sw_busy_set", int'(busy), 4'b0100);
    a_valid = 1'b1;
    a_addr = 2'd2;
    a_data = 16'hBEEF;
    #1;
    check("sw_a_ready", int'(a_ready), 1);
    step();
    a_valid = 1'b0;
    #1;
    check("sw_we", int'(rf_we), 1);
    check("sw_addr", int'(rf_wr_addr), 2);
    check("sw_data", int'(rf_wr_data), 16'hBEEF);
    check("sw_busy_clr", int'(busy), 0);

    // Idle: outputs hold
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("idle_we", int'(rf_we), 0);
      check("idle_addr", int'(rf_wr_addr), 2);
      check("idle_data", int'(rf_wr_data), 16'hBEEF);
    end

    // Hazard queries with busy = 1000
    iss_valid = 1'b1;
    iss_rd = 2'd3;
    step();
    iss_valid = 1'b0;
    chk_en = 1'b1;
    chk_rs1 = 2'd3;
    chk_rs2 = 2'd0;
    chk_rd = 2'd0;
    #1;
    check("hz_busy", int'(busy), 4'b1000);
    check("hz_hit", int'(hazard), 1);
    chk_rs1 = 2'd0;
    chk_rs2 = 2'd1;
    chk_rd = 2'd2;
    #1;
    check("hz_miss", int'(hazard), 0);
    chk_rs1 = 2'd3;
    chk_en = 1'b0;
    #1;
    check("hz_off", int'(hazard), 0);

    // Set/clear collision on r1
    iss_valid = 1'b1;
    iss_rd = 2'd1;
    step();
    a_valid = 1'b1;
    a_addr = 2'd1;
    a_data = 16'h1234;
    step();
    iss_valid = 1'b0;
    #1;
    check("col_we", int'(rf_we), 1);
    check("col_busy", int'(busy), 4'b1010);
    step();
    a_valid = 1'b0;
    b_valid = 1'b1;
    b_addr = 2'd3;
    b_data = 16'h0333;
    #1;
    check("col_clr", int'(busy), 4'b1000);
    step();
    b_valid = 1'b0;
    #1;
    check("b_we", int'(rf_we), 1);
    check("b_data", int'(rf_wr_data), 16'h0333);
    check("b_busy", int'(busy), 0);

    // Contention: both valid for 4 cycles
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_addr = 2'd1;
    b_addr = 2'd3;
    for (int i = 0; i < 4; i++) begin
      int ea;
`ifdef RF_WR_ARB_RR_EN
      ea = (i % 2 == 0) ? 1 : 0;
`else
      ea = 1;
`endif
      a_data = 16'(16'hA000 + i);
      b_data = 16'(16'hB000 + i);
      #1;
      check("cont_a", int'(a_ready), ea);
      check("cont_b", int'(b_ready), 1 - ea);
      step();
      #1;
      check("cont_addr", int'(rf_wr_addr), ea ? 1 : 3);
    end
    idle_in();
    step();

    // Random traffic with a mid-cycle reset
    for (int c = 0; c < 400; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom);
      b_addr = AW'($urandom);
      a_data = DW'($urandom);
      b_data = DW'($urandom);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd = AW'($urandom);
      chk_en = 1'($urandom_range(0, 1));
      chk_rs1 = AW'($urandom);
      chk_rs2 = AW'($urandom);
      chk_rd = AW'($urandom);
      if (c == 200) begin
        #1;
        reset = 1'b1;
        #1;
        check("arst_we", int'(rf_we), 0);
        check("arst_addr", int'(rf_wr_addr), 0);
        check("arst_data", int'(rf_wr_data), 0);
        check("arst_busy", int'(busy), 0);
        idle_in();
        step();
        reset = 1'b0;
      end
      step();
    end
    idle_in();
    step();
    run_cmp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Write-port controller for the 4×16-bit CPU register file. It shares the single write port between two writeback requesters:
- A: ALU/execute writeback.
- B: memory-load return.

A valid/ready handshake arbitrates them, and the winning write is registered onto the file's write-enable, address and data inputs. A per-register busy scoreboard is set when an instruction issues and cleared when its write is driven, so the issue stage can stall on RAW/WAW hazards.

## Interface
- DATA_W, 16, write data width.
- ADDR_W, 2, register address width (2**ADDR_W registers, 4 by default).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A accepted this cycle.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid, b_ready, b_addr, b_data  same as A, for requester B.
- iss_valid  in  1  instruction issuing with a destination register.
- iss_rd  in  ADDR_W  destination to reserve.
- chk_en  in  1  hazard query enable.
- chk_rs1, chk_rs2, chk_rd  in  ADDR_W  sources/destination of the instruction being checked.
- hazard  out  1  combinational: chk_en & (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]).
- rf_we  out  1  registered write enable to register file.
- rf_wr_addr  out  ADDR_W  registered write address.
- rf_wr_data  out  DATA_W  registered write data.
- busy  out  2**ADDR_W  scoreboard bits, bit i = register i has a pending write.

## Operation
- **Transfers and grant**
  - A transfer occurs when valid & ready; at most one transfer per cycle.
  - Grant is combinational from a_valid/b_valid; x_ready = grant_x. Ready may depend on valid; requesters must not make valid depend on ready.
  - Only one valid: that requester is granted.
  - Both valid: the arbitration policy decides (see Configuration).
  - Neither valid: no grant; both ready low.
- **Write output register**
  - On transfer: rf_we<=1, rf_wr_addr<=granted addr, rf_wr_data<=granted data.
  - Otherwise: rf_we<=0; addr/data hold their previous value.
- **Scoreboard (per register i, each edge)**
  - busy[i] <= (busy[i] & ~clr_i) | set_i.
  - set_i = iss_valid & iss_rd==i.
  - clr_i = transfer & granted addr==i.
  - Same-register set and clear on one edge: set wins, busy stays 1.
  - Issue to an already-busy register: stays 1, no counting. The issue stage must use chk_rd to avoid WAW.
  - Write to a non-busy register: performed normally; busy unaffected.
  - Both requesters target the same register: writes are serialised in grant order; the first write clears busy.

## Timing
- Reset (asynchronous) values:
  - rf_we=0, rf_wr_addr=0, rf_wr_data=0, busy=0.
  - Arbitration pointer favours A.
- A reset asserted mid-operation discards in-flight state. Un-accepted requests must be re-presented after reset deasserts.
- Write latency, for a transfer accepted at rising edge N:
  - rf_we is high for cycle N..N+1.
  - The register file captures the write at the falling edge inside that cycle.
  - A read at rising edge N+1 returns the new data.
- Busy latency:
  - The busy bit clears at edge N, so hazard drops in cycle N..N+1, consistent with data being in the file by edge N+1.
  - iss_valid at edge N raises busy from cycle N..N+1 onward.
- hazard and ready are purely combinational: no added latency, no registered stall.

## Configuration
- RF_WR_ARB_RR_EN defined: round-robin policy.
  - A one-bit last-grant pointer updates on every transfer.
  - When both requesters are valid, the requester not granted last wins.
  - Under continuous contention, grants alternate A,B,A,B.
- Undefined: fixed priority, A always beats B; no pointer register. B can starve while A is continuously valid.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle → rf_we=0, rf_wr_addr=0, rf_wr_data=0, busy=4'b0000 immediately, without a clock edge.
- **Single write:** iss_valid with iss_rd=2, then a_valid with a_addr=2, a_data=16'hBEEF one cycle later:
  - busy=4'b0100 after the issue edge.
  - a_ready=1 on the following edge, then rf_we=1, rf_wr_addr=2, rf_wr_data=16'hBEEF, busy=0.
  - File register 2 reads 16'hBEEF at the next rising edge.
- **Contention:** a_valid and b_valid held for 4 cycles, a_addr=1, b_addr=3:
  - With RF_WR_ARB_RR_EN: grants A,B,A,B.
  - Without it: A×4 and b_ready=0 throughout.
- **Set/clear collision:** iss_valid with iss_rd=1 on the same edge that a transfer to register 1 is accepted, busy[1] previously 1 → busy[1]=1 after the edge.
- **Hazard query:** busy=4'b1000, chk_en=1:
  - chk_rs1=3 → hazard=1 in the same cycle.
  - chk_rs1=0, chk_rs2=1, chk_rd=2 → hazard=0.
  - chk_en=0 → hazard=0.
- **Idle:** no valids for 3 cycles after a write → rf_we=0 every cycle; rf_wr_addr and rf_wr_data hold the last values.
